randomizer_stream: RTL and testbench

Parametrised, streaming successor to the team's single-bit PRBS randomizer. Each cycle it XORs DW data bits with a Fibonacci LFSR keystream of configurable width and tap mask. It moves data through a valid/ready handshake with one registered output stage. The LFSR reseeds automatically at every block boundary, as burst/FEC-block randomization requires. It sits between the framer and the channel encoder; the same instance derandomizes on the receive side.

---
 rtl/randomizer_stream_if.sv | 36 +++
 rtl/randomizer_stream.sv | 82 ++++++++
 tb/tb_randomizer_stream.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/randomizer_stream_if.sv
// randomizer_stream_if: valid/ready data stream, seed load and LFSR debug bundle
// master drives load/seed/in_*/out_ready (and bypass when RANDOMIZER_BYPASS_EN is defined);
// slave drives in_ready/out_*/state.
interface randomizer_stream_if #(
  parameter int LFSR_W = 15,
  parameter int DW = 8
);
  logic              load;
  logic [LFSR_W-1:0] seed;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              out_ready;
  logic [LFSR_W-1:0] state;
`ifdef RANDOMIZER_BYPASS_EN
  logic              bypass;
`endif
  modport master (
`ifdef RANDOMIZER_BYPASS_EN
    output bypass,
`endif
    output load, seed, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, state
  );
  modport slave (
`ifdef RANDOMIZER_BYPASS_EN
    input  bypass,
`endif
    input  load, seed, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, state
  );
endinterface

// File: rtl/randomizer_stream.sv
// randomizer_stream: streaming LFSR scrambler/descrambler with per-block automatic reseed
// Ports: clk, reset (sync, active-high), bus (randomizer_stream_if.slave: load/seed,
// in_valid/in_data/in_last/in_ready, out_valid/out_data/out_last/out_ready, state).
// Optional: RANDOMIZER_BYPASS_EN adds bus.bypass to pass beats unscrambled.
module randomizer_stream #(
  parameter int                LFSR_W       = 15,
  parameter logic [LFSR_W-1:0] TAPS         = 15'h0003,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 15'h4A80,
  parameter int                DW           = 8,
  parameter int                BLK_LEN      = 16
) (
  input logic clk,
  input logic reset,
  randomizer_stream_if.slave bus
);
  localparam int CW = BLK_LEN > 1 ? $clog2(BLK_LEN) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t            r_st, w_st_nxt;
  logic [LFSR_W-1:0] r_lfsr, r_seed, w_seed_in, w_lfsr_nxt;
  logic [CW-1:0]     r_cnt;
  logic [DW-1:0]     w_key, r_out_data;
  logic              r_out_valid, r_out_last, w_fire, w_end, w_byp;
`ifdef RANDOMIZER_BYPASS_EN
  assign w_byp = bus.bypass;
`else
  assign w_byp = 1'b0;
`endif
  // zero seed would lock the LFSR, so it is swapped for the default
  assign w_seed_in    = (bus.seed == '0) ? DEFAULT_SEED : bus.seed;
  assign bus.in_ready = !bus.load && (!r_out_valid || bus.out_ready);
  assign w_fire       = bus.in_valid && bus.in_ready;
  assign w_end        = bus.in_last || (r_cnt == CW'(BLK_LEN - 1));
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.state     = r_lfsr;
  // DW keystream steps unrolled in one cycle, bit 0 first
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    w_key = '0;
    for (int i = 0; i < DW; i++) begin
      w_key[i] = ^(w_lfsr_nxt & TAPS);
      w_lfsr_nxt = {w_key[i], w_lfsr_nxt[LFSR_W-1:1]};
    end
  end
  always_comb begin
    w_st_nxt = r_st;
    w_st_nxt = bus.load ? IDLE : (w_fire ? (w_end ? IDLE : RUN) : r_st);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st   <= IDLE;
      r_lfsr <= DEFAULT_SEED;
      r_seed <= DEFAULT_SEED;
      r_cnt  <= '0;
    end else begin
      r_st <= w_st_nxt;
      if (bus.load) begin
        r_seed <= w_seed_in;
        r_lfsr <= w_seed_in;
        r_cnt  <= '0;
      end else if (w_fire) begin
        r_lfsr <= w_end ? r_seed : (w_byp ? r_lfsr : w_lfsr_nxt);
        r_cnt  <= w_end ? '0 : r_cnt + 1'b1;
      end
    end
  end
  // in_ready is low during load, so a pending beat keeps draining independently
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_byp ? bus.in_data : bus.in_data ^ w_key;
      r_out_last  <= w_end;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_randomizer_stream.sv
// tb_randomizer_stream: randomized self-checking bench against a keystream-sequence model
module tb_randomizer_stream;
  localparam logic [14:0] TAPS = 15'h0003;
  localparam logic [14:0] DEF  = 15'h4A80;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [14:0] m_seed, m_state;
  int m_n, m_cnt;
  logic [7:0] orig [16];
  logic [7:0] rec [16];
  randomizer_stream_if #(.LFSR_W(15), .DW(8)) a ();
  randomizer_stream_if #(.LFSR_W(15), .DW(8)) b ();
  randomizer_stream dut1 (.clk(clk), .reset(rst), .bus(a));
  randomizer_stream dut2 (.clk(clk), .reset(rst), .bus(b));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // x[0..14] = seed, x[k+15] = xor of tapped x[k+j]; key bit for step k is x[k+15]
  // returns {state after n+8 steps, key bits for steps n..n+7}
  function automatic logic [22:0] seq(input logic [14:0] sd, input int n);
    logic x [0:400];
    logic [22:0] r;
    logic fb;
    for (int j = 0; j < 15; j++) x[j] = sd[j];
    for (int k = 0; k < n + 8; k++) begin
      fb = 1'b0;
      for (int j = 0; j < 15; j++) if (TAPS[j]) fb = fb ^ x[k+j];
      x[k+15] = fb;
    end
    for (int i = 0; i < 8; i++) r[i] = x[n+15+i];
    for (int j = 0; j < 15; j++) r[8+j] = x[n+8+j];
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    a.load = 1'b0; a.seed = '0; a.in_valid = 1'b0; a.in_data = '0; a.in_last = 1'b0; a.out_ready = 1'b1;
    b.load = 1'b0; b.seed = '0; b.in_valid = 1'b0; b.in_data = '0; b.in_last = 1'b0; b.out_ready = 1'b1;
`ifdef RANDOMIZER_BYPASS_EN
    a.bypass = 1'b0; b.bypass = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_seed = DEF; m_state = DEF; m_n = 0; m_cnt = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic byp, output logic [7:0] got);
    logic [22:0] r;
    logic [7:0] ed;
    logic el;
    int t;
    r = seq(m_seed, m_n);
    ed = byp ? d : d ^ r[7:0];
    el = l || (m_cnt == 15);
    a.in_valid = 1'b1; a.in_data = d; a.in_last = l;
`ifdef RANDOMIZER_BYPASS_EN
    a.bypass = byp;
`endif
    t = 0;
    while (!a.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("accept", a.in_ready, 1);
    got = 'x;
    if (a.in_ready) begin
      @(posedge clk);
      #1 a.in_valid = 1'b0; a.in_last = 1'b0;
      if (el) begin
        m_n = 0; m_cnt = 0; m_state = m_seed;
      end else begin
        m_cnt++;
        if (!byp) begin
          m_n += 8; m_state = r[22:8];
        end
      end
      check("out_valid", a.out_valid, 1);
      check("out_data", a.out_data, ed);
      check("out_last", a.out_last, el);
      check("state", a.state, m_state);
      got = a.out_data;
    end else a.in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [14:0] sd);
    a.load = 1'b1; a.seed = sd; a.in_valid = 1'b1; a.in_data = 8'h3C;
    #1 check("load_ready", a.in_ready, 0);
    @(posedge clk);
    #1 a.load = 1'b0; a.in_valid = 1'b0;
    m_seed = (sd == 0) ? DEF : sd; m_state = m_seed; m_n = 0; m_cnt = 0;
    check("load_state", a.state, m_seed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g, g1, d, sx, y;
    logic sl;
    logic [14:0] ss;
    do_reset();
    check("rst_valid", a.out_valid, 0);
    check("rst_data", a.out_data, 0);
    check("rst_last", a.out_last, 0);
    check("rst_state", a.state, DEF);
    check("rst_ready", a.in_ready, 1);
    send(8'h00, 0, 0, g); check("tp_c0", g, 8'hC0);
    send(8'h00, 0, 0, g); check("tp_6f", g, 8'h6F);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      orig[i] = 8'($urandom);
      send(orig[i], 0, 0, rec[i]);
    end
    check("blk_last16", a.out_last, 1);
    check("blk_state16", a.state, DEF);
    for (int i = 0; i < 16; i++) begin
      b.in_valid = 1'b1; b.in_data = rec[i];
      @(posedge clk);
      #1 check("derand", b.out_data, orig[i]);
    end
    check("derand_last", b.out_last, 1);
    b.in_valid = 1'b0;
    d = 8'($urandom);
    send(d, 0, 0, g1);
    send(d, 0, 0, g);
    send(d, 1, 0, g);
    check("last3", a.out_last, 1);
    send(d, 0, 0, g);
    check("reseed", g, g1);
    send(8'($urandom), 0, 0, g);
    send(8'($urandom), 0, 0, g);
    do_load(15'h0000);
    do_load(15'h7FFF);
    send(8'h00, 0, 0, g); check("ones_zero", g, 8'h00);
    send(8'($urandom), 0, 0, g);
    y = 8'($urandom);
    a.out_ready = 1'b0; a.in_valid = 1'b1; a.in_data = y;
    sx = a.out_data; sl = a.out_last; ss = a.state;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("stall_ready", a.in_ready, 0);
      check("stall_data", a.out_data, sx);
      check("stall_last", a.out_last, sl);
      check("stall_state", a.state, ss);
      check("stall_valid", a.out_valid, 1);
    end
    a.out_ready = 1'b1;
    send(y, 0, 0, g);
    send(8'($urandom), 0, 0, g);
    for (int i = 0; i < 40; i++) send(8'($urandom), ($urandom_range(0, 4) == 0), 0, g);
`ifdef RANDOMIZER_BYPASS_EN
    do_reset();
    send(8'hA5, 0, 1, g);
    check("byp_data", g, 8'hA5);
    check("byp_state", a.state, DEF);
    send(8'h00, 0, 0, g);
    check("byp_c0", g, 8'hC0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
